ws2812_frame_buffer: RTL and testbench

- Double-buffered pixel store directly upstream of the WS2812 serializer. It answers the serializer's address_o with that pixel's R/G/B bytes.
- The host writes a complete frame into the back bank, then requests a swap. The swap is applied only at a serializer frame boundary, so no frame tears.
- A global brightness scaler sits in the read path. The brightness value is latched once per frame.

---
 rtl/ws2812_pkg.sv | 27 ++
 rtl/ws2812_pixel_ram.sv | 25 ++
 rtl/ws2812_frame_buffer.sv | 126 ++++++++++++
 tb/tb_ws2812_frame_buffer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared widths, channel slices, swap FSM encoding and the brightness scaler
// for the WS2812 frame buffer.
package ws2812_pkg;

  localparam int PIXEL_ADDR_W = 9;
  localparam int PIXEL_W      = 24;

  // Channel positions inside a packed {r, g, b} pixel.
  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  // Swap FSM encoding.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  // (c * (b + 1)) >> 8 with a 17-bit product: b=255 is unity, b=0 yields 0.
  function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = 17'(c) * (17'(b) + 17'd1);
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
// Written to map onto a single block RAM.
module ws2812_pixel_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 24
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  // Write port and registered read port share the single clock.
  // NOTE: no reset here on purpose -- a reset would stop the array (and its
  // output register) from mapping onto block RAM; consumers gate stale data.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/ws2812_frame_buffer.sv
// Double-buffered pixel store feeding the WS2812 serializer. The host fills
// the back bank, requests a swap, and the swap lands on the next serializer
// frame boundary. Reads pass through a per-frame brightness scaler.
module ws2812_frame_buffer
  import ws2812_pkg::*;
#(
  parameter int         LED_COUNT          = 256,
  parameter logic [7:0] DEFAULT_BRIGHTNESS = 8'd255
) (
  input  logic                    led_clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [PIXEL_ADDR_W-1:0] wr_addr_i,
  input  logic [PIXEL_W-1:0]      wr_data_i,
  output logic                    wr_ready_o,
  input  logic                    swap_req_i,
  output logic                    swap_busy_o,
  output logic                    swap_done_o,
  input  logic [7:0]              brightness_i,
  input  logic                    frame_sync_i,
  input  logic [PIXEL_ADDR_W-1:0] rd_addr_i,
  output logic [7:0]              led_r_o,
  output logic [7:0]              led_g_o,
  output logic [7:0]              led_b_o
);

  // Pixel index bits actually stored; the bank bit sits above them.
  localparam int PIX_AW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam logic [PIXEL_ADDR_W:0] LED_COUNT_W = (PIXEL_ADDR_W + 1)'(LED_COUNT);

  logic [0:0]         state_q, state_d;
  logic               front_sel_q, front_sel_d;
  logic               front_valid_q, front_valid_d;
  logic               swap_done_q, swap_done_d;
  logic [7:0]         brightness_q;
  logic               rd_in_range_q;
  logic [7:0]         led_r_q, led_g_q, led_b_q;
  logic               ram_we;
  logic [PIXEL_W-1:0] ram_rdata;

  assign wr_ready_o  = (state_q == ST_IDLE);
  assign swap_busy_o = (state_q == ST_PENDING);
  assign swap_done_o = swap_done_q;
  assign led_r_o     = led_r_q;
  assign led_g_o     = led_g_q;
  assign led_b_o     = led_b_q;

  // Host writes land in the back bank; out-of-range or stalled writes vanish.
  assign ram_we = wr_en_i && wr_ready_o && ({1'b0, wr_addr_i} < LED_COUNT_W);

  ws2812_pixel_ram #(
    .ADDR_W(PIX_AW + 1),
    .DATA_W(PIXEL_W)
  ) u_ram (
    .clk_i  (led_clk_i),
    .we_i   (ram_we),
    .waddr_i({~front_sel_q, wr_addr_i[PIX_AW-1:0]}),
    .wdata_i(wr_data_i),
    .raddr_i({front_sel_q, rd_addr_i[PIX_AW-1:0]}),
    .rdata_o(ram_rdata)
  );

  // Swap FSM next state: a request arms it, the next frame boundary commits.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    swap_done_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (swap_req_i) state_d = ST_PENDING;
    end else begin
      if (frame_sync_i) begin
        state_d       = ST_IDLE;
        front_sel_d   = ~front_sel_q;
        front_valid_d = 1'b1;
        swap_done_d   = 1'b1;
      end
    end
  end

  // Swap FSM state, bank select and done pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge led_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      swap_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      swap_done_q   <= swap_done_d;
    end
  end

  // Brightness is sampled only at the frame boundary so a frame never mixes gains.
  always_ff @(posedge led_clk_i or posedge rst_i) begin
    if (rst_i) brightness_q <= DEFAULT_BRIGHTNESS;
    else if (frame_sync_i) brightness_q <= brightness_i;
  end

  // Read path: range flag tracks the RAM stage, then scaled outputs register.
  always_ff @(posedge led_clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_in_range_q <= 1'b0;
      led_r_q       <= 8'd0;
      led_g_q       <= 8'd0;
      led_b_q       <= 8'd0;
    end else begin
      rd_in_range_q <= ({1'b0, rd_addr_i} < LED_COUNT_W);
      if (front_valid_q && rd_in_range_q) begin
        led_r_q <= scale_channel(ram_rdata[R_HI:R_LO], brightness_q);
        led_g_q <= scale_channel(ram_rdata[G_HI:G_LO], brightness_q);
        led_b_q <= scale_channel(ram_rdata[B_HI:B_LO], brightness_q);
      end else begin
        led_r_q <= 8'd0;
        led_g_q <= 8'd0;
        led_b_q <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_frame_buffer.sv
// Directed bench for ws2812_frame_buffer with LED_COUNT=256.
module tb_ws2812_frame_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [8:0] wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic       wr_ready;
  logic       swap_req = 1'b0;
  logic       swap_busy;
  logic       swap_done;
  logic [7:0] brightness = 8'd255;
  logic       frame_sync = 1'b0;
  logic [8:0] rd_addr = '0;
  logic [7:0] led_r, led_g, led_b;

  int total = 0;
  int bad   = 0;

  ws2812_frame_buffer #(.LED_COUNT(256), .DEFAULT_BRIGHTNESS(8'd255)) dut (
    .led_clk_i   (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .swap_req_i  (swap_req),
    .swap_busy_o (swap_busy),
    .swap_done_o (swap_done),
    .brightness_i(brightness),
    .frame_sync_i(frame_sync),
    .rd_addr_i   (rd_addr),
    .led_r_o     (led_r),
    .led_g_o     (led_g),
    .led_b_o     (led_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [8:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_px(input string tag, input logic [8:0] a, input logic [23:0] exp);
    rd_addr = a;
    tick();
    tick();
    check(tag, {8'h0, led_r, led_g, led_b}, {8'h0, exp});
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  initial begin
    // Reset state.
    #12;
    rst = 1'b0;
    tick();
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(swap_busy), 32'd0);
    check("rst_done", 32'(swap_done), 32'd0);
    for (int i = 0; i < 256; i++) read_px("rst_read_zero", 9'(i), 24'h000000);

    // Fill back bank, arm a swap; write in the request cycle is accepted.
    write_px(9'd5, 24'h102030);
    write_px(9'd6, 24'h80FF00);
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = 9'd7; wr_data = 24'h0A0B0C;
    tick();
    swap_req = 1'b0; wr_en = 1'b0;
    check("pend_busy", 32'(swap_busy), 32'd1);
    check("pend_wr_ready", 32'(wr_ready), 32'd0);
    write_px(9'd5, 24'hFFFFFF);  // dropped while pending
    for (int i = 0; i < 98; i++) tick();
    check("pend_busy_late", 32'(swap_busy), 32'd1);
    check("pend_no_done", 32'(swap_done), 32'd0);
    pulse_sync();
    check("swap_done_pulse", 32'(swap_done), 32'd1);
    check("swap_busy_clear", 32'(swap_busy), 32'd0);
    check("swap_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    check("swap_done_once", 32'(swap_done), 32'd0);
    read_px("px5_after_swap", 9'd5, 24'h102030);
    read_px("px7_same_cycle_wr", 9'd7, 24'h0A0B0C);

    // Brightness changes only at the frame boundary.
    brightness = 8'd127;
    read_px("bright_held", 9'd6, 24'h80FF00);
    pulse_sync();
    check("idle_sync_no_done", 32'(swap_done), 32'd0);
    check("idle_sync_no_busy", 32'(swap_busy), 32'd0);
    read_px("bright_px6", 9'd6, 24'h407F00);
    read_px("bright_px5", 9'd5, 24'h081018);
    brightness = 8'd255;
    pulse_sync();
    read_px("bright_restore", 9'd6, 24'h80FF00);

    // Same-cycle request and sync: swap waits for the next sync.
    write_px(9'd5, 24'h112233);
    write_px(9'd0, 24'h000001);
    write_px(9'd256, 24'hAABBCC);  // out of range, dropped
    swap_req = 1'b1; frame_sync = 1'b1;
    tick();
    swap_req = 1'b0; frame_sync = 1'b0;
    check("same_cycle_busy", 32'(swap_busy), 32'd1);
    check("same_cycle_no_done", 32'(swap_done), 32'd0);
    read_px("same_cycle_old_front", 9'd5, 24'h102030);
    pulse_sync();
    check("next_sync_done", 32'(swap_done), 32'd1);
    read_px("px5_new_front", 9'd5, 24'h112233);
    read_px("px0_no_alias", 9'd0, 24'h000001);
    read_px("oob_read_zero", 9'd256, 24'h000000);

    // Reset while pending clears outputs immediately.
    read_px("pre_rst_value", 9'd5, 24'h112233);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("pre_rst_busy", 32'(swap_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", {8'h0, led_r, led_g, led_b}, 32'h0);
    check("async_rst_busy", 32'(swap_busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(swap_busy), 32'd0);
    check("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    pulse_sync();
    check("post_rst_no_done", 32'(swap_done), 32'd0);
    read_px("post_rst_invalid", 9'd5, 24'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
